// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate generator.
// Format tags double as the out_fmt encoding seen by downstream decode.
package imm_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        SH   = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_IMM32  = 7'h1B;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode: instruction word -> XLEN immediate + format tag.
// Illegal flag output exists only when IMMGEN_ILLEGAL_EN is defined.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o
`ifdef IMMGEN_ILLEGAL_EN
    ,
    output logic            illegal_o
`endif
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] imm32;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        fmt_o = NONE;
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt_o = I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_IMM: begin
                if (is_shift) begin
                    fmt_o = SH;
                    imm32 = (XLEN == 64) ? {26'd0, instr_i[25:20]} : {27'd0, instr_i[24:20]};
                end else begin
                    fmt_o = I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_IMM32: begin
                if (is_shift) begin
                    fmt_o = SH;
                    imm32 = {27'd0, instr_i[24:20]};
                end else begin
                    fmt_o = I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_STORE: begin
                fmt_o = S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BRANCH: begin
                fmt_o = B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = U;
                imm32 = {instr_i[31:12], 12'd0};
            end
            OP_JAL: begin
                fmt_o = J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            default: begin
                fmt_o = NONE;
                imm32 = '0;
            end
        endcase
    end

    // Shift amounts keep bit 31 clear, so a uniform sign extension zero-extends them.
    generate
        if (XLEN == 64) begin : g_ext64
            assign imm_o = {{32{imm32[31]}}, imm32};
        end else begin : g_ext32
            assign imm_o = imm32;
        end
    endgenerate

`ifdef IMMGEN_ILLEGAL_EN
    // Only the default arm yields NONE, so the tag alone identifies unsupported opcodes.
    assign illegal_o = (fmt_o == NONE);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode into a 2-entry elastic buffer, 1-cycle latency.
// in_ready depends only on the registered count; optional out_illegal via IMMGEN_ILLEGAL_EN.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_fmt_t        out_fmt
`ifdef IMMGEN_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_t        fmt;
`ifdef IMMGEN_ILLEGAL_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t     dec_entry;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_entry.imm),
        .fmt_o     (dec_entry.fmt)
`ifdef IMMGEN_ILLEGAL_EN
        ,
        .illegal_o (dec_entry.illegal)
`endif
    );

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head register always feeds the outputs; tail holds the second entry when full.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end
        if (push) begin
            if ((count_q == 2'd0) || pop) begin
                head_d = dec_entry;
            end else begin
                tail_d = dec_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_imm = head_q.imm;
    assign out_fmt = head_q.fmt;
`ifdef IMMGEN_ILLEGAL_EN
    assign out_illegal = head_q.illegal;
`endif

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the datapath's decode stage. It accepts raw 32-bit RISC-V instructions over a valid/ready handshake and decodes the immediate for every base format (I, S, B, U, J, plus RV64 shift-amount). It sign-extends each immediate to XLEN and delivers it, with a format tag, through a 2-entry elastic output buffer. It replaces the single-cycle combinational sign extender and adds full format coverage, correct sign extension, backpressure and width parametrisation.

## Interface
- XLEN, 64 — datapath width; legal values 32 or 64.
- clk  in  1  — clock; all state updates on rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- in_valid  in  1  — in_instr is valid this cycle.
- in_ready  out  1  — block can accept an instruction this cycle.
- in_instr  in  32  — raw instruction word.
- out_valid  out  1  — out_imm/out_fmt are valid.
- out_ready  in  1  — consumer takes the head entry this cycle.
- out_imm  out  XLEN  — sign-extended (or zero-extended shamt) immediate.
- out_fmt  out  3  — format tag of type imm_fmt_t.
- out_illegal  out  1  — unsupported opcode (only when IMMGEN_ILLEGAL_EN is defined).

## Operation
- Decode on opcode in_instr[6:0]:
  - I: 0x03, 0x13, 0x1B, 0x67, 0x73 → instr[31:20].
  - S: 0x23 → {instr[31:25], instr[11:7]}.
  - B: 0x63 → {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: 0x37, 0x17 → {instr[31:12], 12'b0}.
  - J: 0x6F → {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Sign extension: bit instr[31] replicated to XLEN for all formats above, including U on XLEN=64.
- Shift exception: opcode 0x13 with funct3 001/101 → fmt SH, imm = zero-extended instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32). Opcode 0x1B with funct3 001/101 → zero-extended instr[24:20].
- Any other opcode: fmt NONE, imm = 0.
- Buffer: 2-entry FIFO of {imm, fmt, illegal}, with a registered count in 0..2.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Head entry drives the outputs.
- in_ready = (count != 2); depends on registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- Simultaneous push and pop at count 1: count stays 1, new entry becomes head on the next cycle, ordering preserved.
- Push and pop at count 0 cannot both occur (nothing to pop).
- Reset, async at any time including mid-transfer: count = 0, in_ready = 1, out_valid = 0, out_imm = 0, out_fmt = NONE, out_illegal = 0; buffered entries are discarded.
- Outputs are stable while out_valid && !out_ready.

## Timing
- Latency: instruction accepted at edge k appears on out_* after edge k (cycle k+1).
- Throughput: 1 instruction/cycle while out_ready is held high.
- Full (count 2): in_ready deasserts in the cycle after the second push, and reasserts the cycle after the first pop.
- Decode is combinational from in_instr into the buffer write port; the outputs come only from registers.

## Configuration
- IMMGEN_ILLEGAL_EN defined:
  - out_illegal port exists.
  - Set to 1 with imm 0 and fmt NONE for unsupported opcodes.
- Not defined:
  - Port absent, and no illegal bit is stored.
  - Unsupported opcodes still yield imm 0 and fmt NONE.

## Structure
- Package imm_pkg holds:
  - imm_fmt_t enum: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6.
  - Opcode constants: OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
- Sub-module imm_decode (purely combinational: instr → imm, fmt, illegal) is instantiated once.
- The FIFO/handshake logic lives in imm_gen_pipe.

## Test plan
- ADDI x1,x0,-1, 0xFFF00093, XLEN=64, out_ready=1 → next cycle: out_valid=1, imm=0xFFFFFFFFFFFFFFFF, fmt=I.
- Back-to-back SD 0xFE21BC23, BEQ 0xFE000EE3, LUI 0x800002B7 → imm 0xFFFFFFFFFFFFFFF8 (S), 0xFFFFFFFFFFFFFFFC (B), 0xFFFFFFFF80000000 (U) on consecutive cycles.
- SLLI x1,x1,63, 0x03F09093 → imm 0x000000000000003F, fmt=SH; same with XLEN=32 and 0x01F09093 → 0x0000001F.
- out_ready=0 while 3 valid instructions are offered → exactly 2 accepted, in_ready=0 after the second; raise out_ready → both emerge in order, third accepted, no loss or duplication.
- Opcode 0x33 (R-type) with IMMGEN_ILLEGAL_EN → imm=0, fmt=NONE, out_illegal=1; without the macro → imm=0, fmt=NONE.
- Assert reset_n low asynchronously with count=2 → out_valid=0, in_ready=1 immediately; after release the first instruction emerges with latency 1.
